// File: rtl/dcache_wb.sv
// dcache_wb -- direct-mapped, write-back, write-allocate data cache.
//
// Sits behind the pipeline Memory stage. Word loads and stores that hit
// complete in the same cycle. A miss raises DStall and runs a one-word-per-beat
// writeback of the dirty victim line (if any), followed by a refill of the
// requested line. The held request then completes as an ordinary hit.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   Den, DWen            access request; 1 = store, 0 = load
//   DAddr, DWriteData    byte address (bits [1:0] ignored), store data
//   DReadData            load data, valid when Den & ~DWen & ~DStall
//   DStall               access not yet complete
//   MemReq, MemWe        memory beat request; 1 = writeback beat, 0 = refill beat
//   MemAddr, MemWData    beat word address, writeback data
//   MemRData, MemAck     refill data; beat completes at the edge where MemAck = 1
module dcache_wb #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Den,
  input  logic        DWen,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWriteData,
  output logic [31:0] DReadData,
  output logic        DStall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck
);

  localparam int IDX_LO   = OFFSET_BITS + 2;
  localparam int TAG_LO   = IDX_LO + INDEX_BITS;
  localparam int TAG_BITS = 32 - TAG_LO;
  localparam int SETS     = 2 ** INDEX_BITS;
  localparam int WORDS    = 2 ** OFFSET_BITS;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;

  localparam logic [OFFSET_BITS-1:0] BEAT0    = '0;
  localparam logic [OFFSET_BITS-1:0] BEAT_ONE = OFFSET_BITS'(1);

  // Storage: data is addressed by {set, word}.
  logic [31:0]         data_array [SETS*WORDS];
  logic [TAG_BITS-1:0] tag_array  [SETS];
  logic [SETS-1:0]     valid;
  logic [SETS-1:0]     dirty;

  logic [1:0]             state;
  logic [OFFSET_BITS-1:0] beat;
  logic [OFFSET_BITS-1:0] beat_inc;
  logic [TAG_BITS-1:0]    miss_tag;
  logic [INDEX_BITS-1:0]  miss_idx;

  // Request address fields.
  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_word;
  logic                   addr_lsb_unused;

  assign req_tag         = DAddr[31:TAG_LO];
  assign req_idx         = DAddr[TAG_LO-1:IDX_LO];
  assign req_word        = DAddr[IDX_LO-1:2];
  assign addr_lsb_unused = ^DAddr[1:0];

  logic idle, hit, miss_start, store_hit, last_beat, refill_wr;

  assign idle       = (state == IDLE);
  assign hit        = Den & valid[req_idx] & (tag_array[req_idx] == req_tag);
  assign miss_start = idle & Den & ~hit;
  assign store_hit  = idle & hit & DWen;
  assign last_beat  = &beat;
  assign beat_inc   = beat + BEAT_ONE;
  assign refill_wr  = (state == REFILL) & MemAck;

  // A stalled pipeline holds Den high; with Den low nothing is waiting on us.
  assign DStall    = Den & (~idle | ~hit);
  assign DReadData = (idle & hit & ~DWen) ? data_array[{req_idx, req_word}] : 32'h0;

  // Control state and the registered memory-side outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      beat     <= BEAT0;
      valid    <= '0;
      dirty    <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= 32'h0;
      MemWData <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (store_hit) dirty[req_idx] <= 1'b1;
          if (miss_start) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            beat     <= BEAT0;
            MemReq   <= 1'b1;
            if (valid[req_idx] & dirty[req_idx]) begin
              state    <= WRITEBACK;
              MemWe    <= 1'b1;
              MemAddr  <= {tag_array[req_idx], req_idx, BEAT0, 2'b00};
              MemWData <= data_array[{req_idx, BEAT0}];
            end else begin
              state          <= REFILL;
              MemWe          <= 1'b0;
              MemAddr        <= {req_tag, req_idx, BEAT0, 2'b00};
              // The line is being overwritten: it must not hit until complete.
              valid[req_idx] <= 1'b0;
            end
          end
        end

        WRITEBACK: begin
          if (MemAck) begin
            if (last_beat) begin
              state           <= REFILL;
              beat            <= BEAT0;
              dirty[miss_idx] <= 1'b0;
              valid[miss_idx] <= 1'b0;
              MemWe           <= 1'b0;
              MemWData        <= 32'h0;
              MemAddr         <= {miss_tag, miss_idx, BEAT0, 2'b00};
            end else begin
              beat     <= beat_inc;
              MemAddr  <= {tag_array[miss_idx], miss_idx, beat_inc, 2'b00};
              MemWData <= data_array[{miss_idx, beat_inc}];
            end
          end
        end

        REFILL: begin
          if (MemAck) begin
            if (last_beat) begin
              state           <= IDLE;
              beat            <= BEAT0;
              valid[miss_idx] <= 1'b1;
              dirty[miss_idx] <= 1'b0;
              MemReq          <= 1'b0;
              MemAddr         <= 32'h0;
            end else begin
              beat    <= beat_inc;
              MemAddr <= {miss_tag, miss_idx, beat_inc, 2'b00};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: data and tag arrays have no reset; valid bits alone decide whether
  // their contents mean anything, which keeps them mappable onto RAM.
  always_ff @(posedge clk) begin
    if (store_hit)             data_array[{req_idx, req_word}] <= DWriteData;
    if (refill_wr)             data_array[{miss_idx, beat}]    <= MemRData;
    if (refill_wr & last_beat) tag_array[miss_idx]             <= miss_tag;
  end

endmodule
